// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register file sequencer/arbiter.
// master: requester/register-file side; slave: the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDRSIZE = 5,
    parameter int unsigned WORDSIZE = 32
);
    logic                req_valid0;
    logic                req_valid1;
    logic [ADDRSIZE-1:0] req_addr0;
    logic [ADDRSIZE-1:0] req_addr1;
    logic [WORDSIZE-1:0] req_data0;
    logic [WORDSIZE-1:0] req_data1;
    logic                req_ready0;
    logic                req_ready1;
    logic                regWrite;
    logic [ADDRSIZE-1:0] writeReg;
    logic [WORDSIZE-1:0] writeData;
    logic                init_done;

    modport master (
        output req_valid0, req_valid1, req_addr0, req_addr1, req_data0, req_data1,
        input  req_ready0, req_ready1, regWrite, writeReg, writeData, init_done
    );

    modport slave (
        input  req_valid0, req_valid1, req_addr0, req_addr1, req_data0, req_data1,
        output req_ready0, req_ready1, regWrite, writeReg, writeData, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register file write-port sequencer: clears registers 1..2^ADDRSIZE-1 after reset, then
// round-robin arbitrates two writeback requesters onto the single registered write port.
module regfile_write_arbiter #(
    parameter int unsigned ADDRSIZE = 5,
    parameter int unsigned WORDSIZE = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);

    typedef enum logic {StInit, StRun} state_e;

    localparam logic [ADDRSIZE-1:0] LastReg = {ADDRSIZE{1'b1}};

    state_e              state_q;
    logic [ADDRSIZE-1:0] init_cnt_q;
    logic                last_q;
    logic                reg_write_q;
    logic [ADDRSIZE-1:0] write_reg_q;
    logic [WORDSIZE-1:0] write_data_q;
    logic                init_done_q;

    logic                grant0;
    logic                grant1;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StRun) begin
            grant0 = bus.req_valid0 && (!bus.req_valid1 || last_q);
            grant1 = bus.req_valid1 && (!bus.req_valid0 || !last_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            init_cnt_q   <= ADDRSIZE'(1);
            last_q       <= 1'b1;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            init_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    reg_write_q  <= 1'b1;
                    write_reg_q  <= init_cnt_q;
                    write_data_q <= '0;
                    init_cnt_q   <= init_cnt_q + ADDRSIZE'(1);
                    if (init_cnt_q == LastReg) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (grant0) begin
                        last_q       <= 1'b0;
                        write_reg_q  <= bus.req_addr0;
                        write_data_q <= bus.req_data0;
                        reg_write_q  <= (bus.req_addr0 != '0);
                    end else if (grant1) begin
                        last_q       <= 1'b1;
                        write_reg_q  <= bus.req_addr1;
                        write_data_q <= bus.req_data1;
                        reg_write_q  <= (bus.req_addr1 != '0);
                    end else begin
                        reg_write_q  <= 1'b0;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign bus.req_ready0 = grant0;
    assign bus.req_ready1 = grant1;
    assign bus.regWrite   = reg_write_q;
    assign bus.writeReg   = write_reg_q;
    assign bus.writeData  = write_data_q;
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a behavioural model pushes the expected
// write-port contents per cycle into a queue that is popped after each clock edge.
module tb_regfile_write_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    regfile_write_arbiter_if #(.ADDRSIZE(AW), .WORDSIZE(DW)) bus ();

    regfile_write_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    exp_t exp_q[$];
    logic          m_run;
    int            m_cnt;
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_done;
    logic          exp_r0;
    logic          exp_r1;

    task automatic model_reset();
        exp_q.delete();
        m_run  = 1'b0;
        m_cnt  = 1;
        m_last = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_done = 1'b0;
    endtask

    // Drive one cycle of requests and predict readies and the registered write it causes.
    task automatic apply(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t e;
        bus.req_valid0 = v0;
        bus.req_addr0  = a0;
        bus.req_data0  = d0;
        bus.req_valid1 = v1;
        bus.req_addr1  = a1;
        bus.req_data1  = d1;
        e.we = 1'b0;
        if (!m_run) begin
            exp_r0 = 1'b0;
            exp_r1 = 1'b0;
            e.we   = 1'b1;
            m_addr = AW'(m_cnt);
            m_data = '0;
            if (m_cnt == (1 << AW) - 1) begin
                m_run  = 1'b1;
                m_done = 1'b1;
            end
            m_cnt++;
        end else begin
            exp_r0 = v0 && (!v1 || m_last);
            exp_r1 = v1 && (!v0 || !m_last);
            if (exp_r0) begin
                m_last = 1'b0;
                m_addr = a0;
                m_data = d0;
                e.we   = (a0 != '0);
            end else if (exp_r1) begin
                m_last = 1'b1;
                m_addr = a1;
                m_data = d1;
                e.we   = (a1 != '0);
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        model_reset();
        apply(1'b0, '0, '0, 1'b0, '0, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.regWrite, bus.writeReg, bus.writeData, bus.init_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b reg=%0d data=%h done=%b want all zero",
                     bus.regWrite, bus.writeReg, bus.writeData, bus.init_done);
        end
        tests_run++;
        if ({bus.req_ready1, bus.req_ready0} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got %b%b want 00", bus.req_ready1, bus.req_ready0);
        end
    endtask

    // Runs n cycles with fixed stimulus, checking readies and the popped expectation each cycle.
    task automatic test_sweep();
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            tests_run++;
            if ({bus.req_ready1, bus.req_ready0} !== {exp_r1, exp_r0}) begin
                fails++;
                $display("FAIL sweep_ready c%0d: got %b%b want %b%b", i,
                         bus.req_ready1, bus.req_ready0, exp_r1, exp_r0);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.regWrite, bus.writeReg, bus.writeData, bus.init_done} !== e) begin
                fails++;
                $display("FAIL sweep_write edge%0d: got we=%b reg=%0d data=%h done=%b want we=%b reg=%0d data=%h done=%b",
                         i + 1, bus.regWrite, bus.writeReg, bus.writeData, bus.init_done,
                         e.we, e.addr, e.data, e.done);
            end
        end
    endtask

    task automatic run_traffic(input string name, input int n,
                               input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            apply(v0, a0, d0, v1, a1, d1);
            #1;
            tests_run++;
            if ({bus.req_ready1, bus.req_ready0} !== {exp_r1, exp_r0}) begin
                fails++;
                $display("FAIL %s_ready c%0d: got %b%b want %b%b", name, i,
                         bus.req_ready1, bus.req_ready0, exp_r1, exp_r0);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s_scoreboard c%0d: got empty queue want entry", name, i);
            end else begin
                e = exp_q.pop_front();
                if ({bus.regWrite, bus.writeReg, bus.writeData, bus.init_done} !== e) begin
                    fails++;
                    $display("FAIL %s_write c%0d: got we=%b reg=%0d data=%h done=%b want we=%b reg=%0d data=%h done=%b",
                             name, i, bus.regWrite, bus.writeReg, bus.writeData, bus.init_done,
                             e.we, e.addr, e.data, e.done);
                end
            end
        end
    endtask

    task automatic test_single();
        run_traffic("single", 1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        run_traffic("single_idle", 1, 1'b0, '0, '0, 1'b0, '0, '0);
        tests_run++;
        if (bus.writeReg !== 5'd5 || bus.writeData !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_hold: got reg=%0d data=%h want reg=5 data=deadbeef",
                     bus.writeReg, bus.writeData);
        end
    endtask

    task automatic test_zero_addr();
        run_traffic("zero_addr", 1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        run_traffic("zero_idle", 1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] grants;
        grants = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid0 = 1'b1;
            bus.req_addr0  = 5'd3;
            bus.req_data0  = 32'hAAAA0003;
            bus.req_valid1 = 1'b1;
            bus.req_addr1  = 5'd7;
            bus.req_data1  = 32'hBBBB0007;
            #1;
            grants[i] = bus.req_ready1;
            #1;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (grants !== 4'b1010) begin
            fails++;
            $display("FAIL b2b_alternation: got grants(port1 per cycle, lsb first)=%b want 1010",
                     grants);
        end
        // Pointer now favours port 0 again, so the model picks up from a known state.
        m_last = 1'b1;
        m_addr = 5'd7;
        m_data = 32'hBBBB0007;
        exp_q.delete();
        run_traffic("b2b", 4, 1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007);
        run_traffic("b2b_same", 2, 1'b1, 5'd9, 32'h11110000, 1'b1, 5'd9, 32'h22220000);
        run_traffic("b2b_idle", 1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_sweep();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run_traffic("presweep", 10, 1'b0, '0, '0, 1'b0, '0, '0);
        tests_run++;
        if (bus.writeReg !== 5'd10) begin
            fails++;
            $display("FAIL mid_sweep_pos: got reg=%0d want 10", bus.writeReg);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.regWrite, bus.writeReg, bus.writeData, bus.init_done} !== '0) begin
            fails++;
            $display("FAIL mid_sweep_reset: got we=%b reg=%0d data=%h done=%b want all zero",
                     bus.regWrite, bus.writeReg, bus.writeData, bus.init_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        run_traffic("init_pending", 31, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, '0, '0);
        run_traffic("first_run", 1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, '0, '0);
        run_traffic("after_run", 1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bus.req_valid0 = 1'b0;
        bus.req_valid1 = 1'b0;
        bus.req_addr0  = '0;
        bus.req_addr1  = '0;
        bus.req_data0  = '0;
        bus.req_data1  = '0;
        test_reset();
        test_sweep();
        test_single();
        test_zero_addr();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
